// File: rtl/mult_sat_seq_pkg.sv
// Shared types for the sequential saturating fixed-point multiplier.
package mult_sat_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StNorm = 2'd2
  } state_e;

  // Two's-complement magnitude of a value up to 32 bits wide; the caller slices the result.
  function automatic logic [31:0] abs32(input logic [31:0] val, input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (val[width-1]) begin
      abs32 = (~val + 32'd1) & mask;
    end else begin
      abs32 = val & mask;
    end
  endfunction

endpackage

// File: rtl/mult_sat_seq_sat_clip.sv
// Clamps a sign/magnitude product into a Width-bit two's-complement result.
module mult_sat_seq_sat_clip #(
  parameter int unsigned Width = 16
) (
  input  logic               i_sign,
  input  logic [2*Width-1:0] i_mag,
  output logic [Width-1:0]   o_y,
  output logic               o_sat
);

  localparam logic [Width-1:0]   SatMax = {1'b0, {(Width-1){1'b1}}};
  localparam logic [Width-1:0]   SatMin = {1'b1, {(Width-1){1'b0}}};
  localparam logic [2*Width-1:0] MagMax = {{(Width+1){1'b0}}, {(Width-1){1'b1}}};
  localparam logic [2*Width-1:0] MagMin = {{Width{1'b0}}, 1'b1, {(Width-1){1'b0}}};

  logic [Width-1:0] w_mag_lo;
  assign w_mag_lo = i_mag[Width-1:0];

  always_comb begin
    o_y   = '0;
    o_sat = 1'b0;
    if (!i_sign) begin
      if (i_mag > MagMax) begin
        o_y   = SatMax;
        o_sat = 1'b1;
      end else begin
        o_y = w_mag_lo;
      end
    end else begin
      // A magnitude of exactly 2^(W-1) is representable on the negative side.
      if (i_mag > MagMin) begin
        o_y   = SatMin;
        o_sat = 1'b1;
      end else begin
        o_y = ~w_mag_lo + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_sat_seq.sv
// Radix-2 shift-add signed Q-format multiplier with saturation and start/done handshake.
// Define ROUND_EN for round-half-away-from-zero instead of truncation toward zero.
module mult_sat_seq
  import mult_sat_seq_pkg::*;
#(
  parameter int unsigned Width    = 16,
  parameter int unsigned FracBits = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  output logic [Width-1:0] Y,
  output logic             done,
  output logic             busy,
  output logic             sat
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

  state_e r_state, w_state_next;

  logic [2*Width-1:0] r_acc;
  logic [2*Width-1:0] r_mcand;
  logic [Width-1:0]   r_mplier;
  logic [CntW-1:0]    r_cnt;
  logic               r_sign;
  logic [Width-1:0]   r_y;
  logic               r_sat;
  logic               r_done;

  logic               w_load;
  logic               w_step;
  logic               w_norm;
  logic               w_busy;
  logic [Width-1:0]   w_abs_a;
  logic [Width-1:0]   w_abs_b;
  logic [31:0]        w_abs_a32;
  logic [31:0]        w_abs_b32;
  logic [2*Width-1:0] w_acc_rnd;
  logic [2*Width-1:0] w_mag;
  logic [Width-1:0]   w_y;
  logic               w_sat;

  assign w_abs_a32 = abs32(32'(A), Width);
  assign w_abs_b32 = abs32(32'(B), Width);
  assign w_abs_a   = w_abs_a32[Width-1:0];
  assign w_abs_b   = w_abs_b32[Width-1:0];

`ifdef ROUND_EN
  localparam int unsigned RndSh = (FracBits > 0) ? FracBits - 1 : 0;
  localparam logic [2*Width-1:0] RndAdd =
      (FracBits > 0) ? ((2*Width)'(1) << RndSh) : '0;
  // acc never exceeds 2^(2W-2), so the addend cannot overflow 2W bits.
  assign w_acc_rnd = r_acc + RndAdd;
`else
  assign w_acc_rnd = r_acc;
`endif

  assign w_mag = w_acc_rnd >> FracBits;

  mult_sat_seq_sat_clip #(
    .Width (Width)
  ) u_sat_clip (
    .i_sign (r_sign),
    .i_mag  (w_mag),
    .o_y    (w_y),
    .o_sat  (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (start) w_state_next = StCalc;
      StCalc: if (r_cnt == CntLast) w_state_next = StNorm;
      StNorm: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_norm = 1'b0;
    w_busy = 1'b0;
    unique case (r_state)
      StIdle: w_load = start;
      StCalc: begin
        w_step = 1'b1;
        w_busy = 1'b1;
      end
      StNorm: begin
        w_norm = 1'b1;
        w_busy = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_y      <= '0;
      r_sat    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_norm;
      if (w_load) begin
        r_acc    <= '0;
        r_mcand  <= {{Width{1'b0}}, w_abs_a};
        r_mplier <= w_abs_b;
        r_cnt    <= '0;
        r_sign   <= A[Width-1] ^ B[Width-1];
      end
      if (w_step) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end
      if (w_norm) begin
        r_y   <= w_y;
        r_sat <= w_sat;
      end
    end
  end

  assign Y    = r_y;
  assign sat  = r_sat;
  assign done = r_done;
  assign busy = w_busy;

endmodule

// File: tb/tb_mult_sat_seq.sv
// Directed self-checking bench for mult_sat_seq at Width=16, FracBits=8.
module tb_mult_sat_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] Y;
  logic        done;
  logic        busy;
  logic        sat;

  int n_cmp  = 0;
  int n_fail = 0;

  mult_sat_seq #(
    .Width    (16),
    .FracBits (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Y     (Y),
    .done  (done),
    .busy  (busy),
    .sat   (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start high; returns #1 after the edge that samples start.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges from the sampling edge until done; bounded at 40 edges.
  task automatic wait_done(input string tag, input logic [15:0] ey, input logic esat);
    int n;
    n = 0;
    while (!done && n <= 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, 17);
    check({tag, "_y"}, Y, ey);
    check({tag, "_sat"}, sat, esat);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] ey, input logic esat);
    @(negedge clk);
    issue(a, b);
    check({tag, "_busy_calc"}, busy, 1'b1);
    wait_done(tag, ey, esat);
  endtask

  initial begin
    int n;
    int n_done;
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    #12;
    check("rst_y", Y, 16'h0000);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sat", sat, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run("p1p5x2", 16'h0180, 16'h0200, 16'h0300, 1'b0);
    // Y must hold and done drop after the pulse
    @(posedge clk); #1;
    check("hold_y", Y, 16'h0300);
    check("done_pulse", done, 1'b0);
    run("m1p5x2", 16'hFE80, 16'h0200, 16'hFD00, 1'b0);
    run("sat_pos", 16'h7F00, 16'h0200, 16'h7FFF, 1'b1);
    run("sat_neg", 16'h8100, 16'h0200, 16'h8000, 1'b1);
    run("min_sq", 16'h8000, 16'h8000, 16'h7FFF, 1'b1);
    run("min_x1", 16'h8000, 16'h0100, 16'h8000, 1'b0);
`ifdef ROUND_EN
    run("half_pos", 16'h0001, 16'h0080, 16'h0001, 1'b0);
    run("half_neg", 16'hFFFF, 16'h0080, 16'hFFFF, 1'b0);
`else
    run("half_pos", 16'h0001, 16'h0080, 16'h0000, 1'b0);
    run("half_neg", 16'hFFFF, 16'h0080, 16'h0000, 1'b0);
`endif

    // Starts at edges k+3 and k+10 while busy must be ignored.
    @(negedge clk);
    issue(16'h0180, 16'h0200);
    n      = 0;
    n_done = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        n_done++;
        check("ign_lat", n, 17);
        check("ign_y", Y, 16'h0300);
      end
      start = (n == 2) || (n == 9);
      A     = 16'h7F00;
      B     = 16'h7F00;
    end
    start = 1'b0;
    check("ign_ndone", n_done, 1);

    // Back-to-back: start presented in the cycle done is high.
    run("b2b_a", 16'hFE80, 16'h0200, 16'hFD00, 1'b0);
    check("b2b_done_hi", done, 1'b1);
    issue(16'h0180, 16'h0200);
    wait_done("b2b_b", 16'h0300, 1'b0);

    // Reset mid-CALC aborts with no done pulse.
    @(negedge clk);
    issue(16'h7F00, 16'h0200);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_y", Y, 16'h0000);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sat", sat, 1'b0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("abort_nodone", n_done, 0);
    run("post_rst", 16'h0180, 16'h0200, 16'h0300, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
